four_bit_shift_reg: RTL and testbench

//  Serial-in / parallel-out shift register, default 4 bits wide.

---
 rtl/four_bit_shift_reg.sv | 56 +++++
 tb/tb_four_bit_shift_reg.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/four_bit_shift_reg.sv
// Serial-in / parallel-out shift register with selectable shift direction and reset value.
// Optional serial output dout is enabled by defining FOUR_BIT_SHIFT_REG_DOUT_EN.
module four_bit_shift_reg #(
   parameter int               WIDTH      = 4,
   parameter int               SHIFT_LEFT = 1,
   parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
`ifdef FOUR_BIT_SHIFT_REG_DOUT_EN
   output logic             dout,
`endif
   output logic [WIDTH-1:0] Q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Direction is fixed at elaboration, so only one shift path is built.
   generate
      if (SHIFT_LEFT != 0) begin : g_left
         always_comb begin
            q_d = q_q;
            q_d = {q_q[WIDTH-2:0], din};
         end
      end else begin : g_right
         always_comb begin
            q_d = q_q;
            q_d = {din, q_q[WIDTH-1:1]};
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q <= RST_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign Q = q_q;

`ifdef FOUR_BIT_SHIFT_REG_DOUT_EN
   // dout is the bit the next shift discards; chaining it into another din doubles the length.
   generate
      if (SHIFT_LEFT != 0) begin : g_dout_left
         assign dout = q_q[WIDTH-1];
      end else begin : g_dout_right
         assign dout = q_q[0];
      end
   endgenerate
`endif

endmodule

// File: tb/tb_four_bit_shift_reg.sv
// Directed self-checking bench for four_bit_shift_reg: a left-shifting default instance
// and a right-shifting instance with a non-zero reset value.
module tb_four_bit_shift_reg;

   logic       clk;
   logic       rst_l;
   logic       din_l;
   logic [3:0] q_l;
   logic       rst_r;
   logic       din_r;
   logic [3:0] q_r;
`ifdef FOUR_BIT_SHIFT_REG_DOUT_EN
   logic       dout_l;
   logic       dout_r;
`endif

   int total;
   int bad;

   four_bit_shift_reg #(.WIDTH(4), .SHIFT_LEFT(1), .RST_VAL(4'b0000)) dut_l (
      .clk (clk),
      .rst (rst_l),
      .din (din_l),
`ifdef FOUR_BIT_SHIFT_REG_DOUT_EN
      .dout(dout_l),
`endif
      .Q   (q_l)
   );

   four_bit_shift_reg #(.WIDTH(4), .SHIFT_LEFT(0), .RST_VAL(4'b1010)) dut_r (
      .clk (clk),
      .rst (rst_r),
      .din (din_r),
`ifdef FOUR_BIT_SHIFT_REG_DOUT_EN
      .dout(dout_r),
`endif
      .Q   (q_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_l = 1'b0;
      din_l = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         total++;
         if (q_l !== 4'b0000) begin
            bad++;
            $display("FAIL reset_hold[%0d]: got %b expected %b", i, q_l, 4'b0000);
         end
      end
      rst_l = 1'b1;
      din_l = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (q_l !== 4'b0000) begin
         bad++;
         $display("FAIL reset_release: got %b expected %b", q_l, 4'b0000);
      end
   endtask

   task automatic test_pattern();
      logic [3:0] bits;
      logic [3:0] exp [4];
      bits = 4'b1101;
      exp[0] = 4'b0001;
      exp[1] = 4'b0010;
      exp[2] = 4'b0101;
      exp[3] = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         din_l = bits[i];
         @(posedge clk);
         #1;
         total++;
         if (q_l !== exp[i]) begin
            bad++;
            $display("FAIL pattern[%0d]: got %b expected %b", i, q_l, exp[i]);
         end
      end
   endtask

   task automatic test_flush();
      logic [3:0] exp [8];
      exp[0] = 4'b0111;
      exp[1] = 4'b1111;
      exp[2] = 4'b1111;
      exp[3] = 4'b1111;
      exp[4] = 4'b1110;
      exp[5] = 4'b1100;
      exp[6] = 4'b1000;
      exp[7] = 4'b0000;
      for (int i = 0; i < 8; i++) begin
         din_l = (i < 4) ? 1'b1 : 1'b0;
         @(posedge clk);
         #1;
         total++;
         if (q_l !== exp[i]) begin
            bad++;
            $display("FAIL flush[%0d]: got %b expected %b", i, q_l, exp[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [3:0] bits;
      bits = 4'b1101;
      for (int i = 0; i < 4; i++) begin
         din_l = bits[i];
         @(posedge clk);
         #1;
      end
      total++;
      if (q_l !== 4'b1011) begin
         bad++;
         $display("FAIL async_preload: got %b expected %b", q_l, 4'b1011);
      end
      // Assert reset mid-cycle, well clear of either edge.
      #3;
      rst_l = 1'b0;
      din_l = 1'b1;
      #1;
      total++;
      if (q_l !== 4'b0000) begin
         bad++;
         $display("FAIL async_clear: got %b expected %b", q_l, 4'b0000);
      end
      @(posedge clk);
      #1;
      total++;
      if (q_l !== 4'b0000) begin
         bad++;
         $display("FAIL async_hold: got %b expected %b", q_l, 4'b0000);
      end
      rst_l = 1'b1;
      din_l = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (q_l !== 4'b0001) begin
         bad++;
         $display("FAIL async_release_shift: got %b expected %b", q_l, 4'b0001);
      end
   endtask

   task automatic test_sampling();
      // din pulses high between edges but is low at the edge, so a 0 is captured.
      din_l = 1'b1;
      #4;
      din_l = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (q_l !== 4'b0010) begin
         bad++;
         $display("FAIL sampling: got %b expected %b", q_l, 4'b0010);
      end
   endtask

   task automatic test_direction();
      logic [3:0] exp [2];
      exp[0] = 4'b1101;
      exp[1] = 4'b1110;
      rst_r = 1'b0;
      #1;
      total++;
      if (q_r !== 4'b1010) begin
         bad++;
         $display("FAIL right_reset: got %b expected %b", q_r, 4'b1010);
      end
      @(posedge clk);
      #1;
      rst_r = 1'b1;
      for (int i = 0; i < 2; i++) begin
         din_r = 1'b1;
         @(posedge clk);
         #1;
         total++;
         if (q_r !== exp[i]) begin
            bad++;
            $display("FAIL right_shift[%0d]: got %b expected %b", i, q_r, exp[i]);
         end
      end
   endtask

`ifdef FOUR_BIT_SHIFT_REG_DOUT_EN
   task automatic test_dout();
      logic [4:0] bits;
      logic [4:0] exp_dout;
      logic [3:0] exp_q [5];
      bits     = 5'b00001;
      exp_dout = 5'b01000;
      exp_q[0] = 4'b0001;
      exp_q[1] = 4'b0010;
      exp_q[2] = 4'b0100;
      exp_q[3] = 4'b1000;
      exp_q[4] = 4'b0000;
      rst_l = 1'b0;
      #1;
      total++;
      if (dout_l !== 1'b0) begin
         bad++;
         $display("FAIL dout_reset: got %b expected %b", dout_l, 1'b0);
      end
      @(posedge clk);
      #1;
      rst_l = 1'b1;
      for (int i = 0; i < 5; i++) begin
         din_l = bits[i];
         @(posedge clk);
         #1;
         total++;
         if (dout_l !== exp_dout[i] || q_l !== exp_q[i]) begin
            bad++;
            $display("FAIL dout_shift[%0d]: got dout=%b Q=%b expected dout=%b Q=%b",
                     i, dout_l, q_l, exp_dout[i], exp_q[i]);
         end
      end
      total++;
      if (dout_r !== 1'b0) begin
         bad++;
         $display("FAIL dout_right_idle: got %b expected %b", dout_r, 1'b0);
      end
      din_r = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (dout_r !== 1'b1 || q_r !== 4'b0111) begin
         bad++;
         $display("FAIL dout_right_shift: got dout=%b Q=%b expected dout=1 Q=0111", dout_r, q_r);
      end
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      rst_l = 1'b0;
      rst_r = 1'b0;
      din_l = 1'b0;
      din_r = 1'b0;
      test_reset();
      test_pattern();
      test_flush();
      test_async_reset();
      test_sampling();
      test_direction();
`ifdef FOUR_BIT_SHIFT_REG_DOUT_EN
      test_dout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
